// File: rtl/encoder_value_ctrl.sv
// encoder_value_ctrl: one incremental rotary encoder shared between 2**CH_W
// bounded value registers. NAV mode moves the channel cursor, EDIT mode steps
// the value of the selected channel (saturating or wrapping).
// Optional build macro ENC_ACCEL_EN: detents that arrive closer than
// ACCEL_WINDOW cycles after the previous accepted EDIT detent step by
// ACCEL_STEP instead of 1.
//
// Pulse contract: i_cnt and i_btn are single-cycle strobes sampled on i_clk;
// i_cnt_cw is meaningful only while i_cnt is high. o_upd is a single-cycle
// strobe and o_upd_ch is meaningful only while o_upd is high. There is no
// back-pressure: every strobe is consumed in the cycle it is seen.
module encoder_value_ctrl #(
    parameter int CH_W         = 2,
    parameter int WIDTH        = 8,
    parameter int MIN_VAL      = 0,
    parameter int MAX_VAL      = 255,
    parameter int RESET_VAL    = 0,
    parameter int WRAP         = 0,
    parameter int TIMEOUT      = 12000000,
    parameter int ACCEL_WINDOW = 120000,
    parameter int ACCEL_STEP   = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_cnt,
    input  logic                        i_cnt_cw,
    input  logic                        i_btn,
    output logic                        o_mode,
    output logic [CH_W-1:0]             o_ch,
    output logic [WIDTH-1:0]            o_value,
    output logic [WIDTH*(2**CH_W)-1:0]  o_values,
    output logic                        o_upd,
    output logic [CH_W-1:0]             o_upd_ch
);

    localparam int NCH   = 2**CH_W;
    localparam int W1    = WIDTH + 1;
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    // All value arithmetic is carried one bit wider than the registers.
    localparam logic [WIDTH:0]   MIN_X   = W1'(MIN_VAL);
    localparam logic [WIDTH:0]   MAX_X   = W1'(MAX_VAL);
    localparam logic [WIDTH:0]   RANGE_X = W1'(MAX_VAL - MIN_VAL + 1);
    localparam logic [WIDTH-1:0] RST_V   = WIDTH'(RESET_VAL);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [TMO_W-1:0] TMO_SAT  = TMO_W'(TIMEOUT);

    typedef enum logic {
        NAV  = 1'b0,
        EDIT = 1'b1
    } mode_t;

    mode_t             state, state_nxt;
    logic [TMO_W-1:0]  tmo_cnt, tmo_nxt;
    logic [CH_W-1:0]   ch_q, ch_nxt;
    logic [WIDTH-1:0]  vals_q [NCH];
    logic [WIDTH-1:0]  vals_nxt [NCH];
    logic [WIDTH-1:0]  value_q;
    logic              upd_q, upd_nxt;
    logic [CH_W-1:0]   upd_ch_q, upd_ch_nxt;

    logic [WIDTH-1:0]  cur_val;
    logic [WIDTH-1:0]  stepped;
    logic [WIDTH:0]    step;
    logic [WIDTH:0]    off;
    logic [WIDTH:0]    step_mod;

    assign cur_val = vals_q[ch_q];

`ifdef ENC_ACCEL_EN
    localparam int ACC_W = $clog2(ACCEL_WINDOW + 1);
    localparam logic [ACC_W-1:0] ACC_SAT = ACC_W'(ACCEL_WINDOW);

    logic [ACC_W-1:0] acc_cnt;
    logic             edit_pulse;

    assign edit_pulse = (state == EDIT) && !i_btn && i_cnt;
    assign step = (acc_cnt < ACC_SAT) ? W1'(ACCEL_STEP) : W1'(1);

    // Cycles since the last accepted EDIT detent; saturated on EDIT entry so
    // the first detent of an edit session is always a slow one.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_cnt <= ACC_SAT;
        end else if ((state == NAV) && i_btn) begin
            acc_cnt <= ACC_SAT;
        end else if (edit_pulse) begin
            acc_cnt <= '0;
        end else if (acc_cnt != ACC_SAT) begin
            acc_cnt <= acc_cnt + 1'b1;
        end
    end
`else
    assign step = W1'(1);
`endif

    // New value of the selected channel for one detent in the given direction.
    always_comb begin
        stepped  = cur_val;
        off      = {1'b0, cur_val} - MIN_X;
        step_mod = step % RANGE_X;
        if (WRAP != 0) begin
            if (i_cnt_cw) begin
                stepped = WIDTH'(MIN_X + ((off + step) % RANGE_X));
            end else begin
                stepped = WIDTH'(MIN_X + ((off + RANGE_X - step_mod) % RANGE_X));
            end
        end else begin
            if (i_cnt_cw) begin
                if (({1'b0, cur_val} + step) > MAX_X) begin
                    stepped = WIDTH'(MAX_X);
                end else begin
                    stepped = WIDTH'({1'b0, cur_val} + step);
                end
            end else begin
                if ({1'b0, cur_val} < (MIN_X + step)) begin
                    stepped = WIDTH'(MIN_X);
                end else begin
                    stepped = WIDTH'({1'b0, cur_val} - step);
                end
            end
        end
    end

    // Mode FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= NAV;
        end else begin
            state <= state_nxt;
        end
    end

    // Next mode, timeout, cursor and value; the button always beats a detent,
    // and a detent always beats a timeout expiry.
    always_comb begin
        state_nxt  = state;
        tmo_nxt    = tmo_cnt;
        ch_nxt     = ch_q;
        vals_nxt   = vals_q;
        upd_nxt    = 1'b0;
        upd_ch_nxt = upd_ch_q;
        case (state)
            NAV: begin
                tmo_nxt = '0;
                if (i_btn) begin
                    state_nxt = EDIT;
                end else if (i_cnt) begin
                    ch_nxt = i_cnt_cw ? ch_q + 1'b1 : ch_q - 1'b1;
                end
            end
            EDIT: begin
                if (i_btn) begin
                    state_nxt = NAV;
                    tmo_nxt   = '0;
                end else if (i_cnt) begin
                    tmo_nxt        = '0;
                    vals_nxt[ch_q] = stepped;
                    if (stepped != cur_val) begin
                        upd_nxt    = 1'b1;
                        upd_ch_nxt = ch_q;
                    end
                end else if ((TIMEOUT != 0) && (tmo_cnt == TMO_LAST)) begin
                    state_nxt = NAV;
                    tmo_nxt   = '0;
                end else if (tmo_cnt != TMO_SAT) begin
                    tmo_nxt = tmo_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = NAV;
            end
        endcase
    end

    // Datapath registers; o_value is registered from the next-state view so it
    // always matches o_ch and o_values in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_cnt  <= '0;
            ch_q     <= '0;
            value_q  <= RST_V;
            upd_q    <= 1'b0;
            upd_ch_q <= '0;
            for (int k = 0; k < NCH; k++) begin
                vals_q[k] <= RST_V;
            end
        end else begin
            tmo_cnt  <= tmo_nxt;
            ch_q     <= ch_nxt;
            value_q  <= vals_nxt[ch_nxt];
            upd_q    <= upd_nxt;
            upd_ch_q <= upd_ch_nxt;
            for (int k = 0; k < NCH; k++) begin
                vals_q[k] <= vals_nxt[k];
            end
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_pack
        assign o_values[k*WIDTH +: WIDTH] = vals_q[k];
    end

    assign o_mode   = (state == EDIT);
    assign o_ch     = ch_q;
    assign o_value  = value_q;
    assign o_upd    = upd_q;
    assign o_upd_ch = upd_ch_q;

endmodule
